// File: rtl/usb_rx_bit_unstuff.sv
// rtl/usb_rx_bit_unstuff.sv - USB receive SYNC hunt, bit unstuffing and LSB-first byte deserializer
module usb_rx_bit_unstuff #(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int STUFF_LEN      = 6
) (
    input  logic       gclk,
    input  logic       reset,
    input  logic       rx_data_in,
    input  logic       rx_data_valid,
    input  logic       rx_eop,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       rx_sync_det,
    output logic       rx_pkt_end,
    output logic       rx_stuff_err,
    output logic       rx_align_err,
    output logic       rx_active
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [2:0] SYNC_ZEROS = 3'(SYNC_MIN_ZEROS);
    localparam logic [2:0] STUFF_AT   = 3'(STUFF_LEN);

    state_t     state;
    logic [2:0] zero_cnt;
    logic [2:0] ones_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    // Packet framing FSM; every output is registered and pulse outputs default low each cycle.
    always_ff @(posedge gclk) begin
        if (reset) begin
            state         <= HUNT;
            zero_cnt      <= 3'd0;
            ones_cnt      <= 3'd0;
            bit_cnt       <= 3'd0;
            shreg         <= 8'h00;
            rx_byte       <= 8'h00;
            rx_byte_valid <= 1'b0;
            rx_sync_det   <= 1'b0;
            rx_pkt_end    <= 1'b0;
            rx_stuff_err  <= 1'b0;
            rx_align_err  <= 1'b0;
            rx_active     <= 1'b0;
        end else begin
            rx_byte_valid <= 1'b0;
            rx_sync_det   <= 1'b0;
            rx_pkt_end    <= 1'b0;
            rx_stuff_err  <= 1'b0;
            rx_align_err  <= 1'b0;
            case (state)
                HUNT: begin
                    // A stray end-of-packet restarts the zero count so SYNC must be seen afresh.
                    if (rx_eop) begin
                        zero_cnt <= 3'd0;
                    end else if (rx_data_valid) begin
                        if (rx_data_in) begin
                            zero_cnt <= 3'd0;
                            if (zero_cnt >= SYNC_ZEROS) begin
                                rx_sync_det <= 1'b1;
                                rx_active   <= 1'b1;
                                // The SYNC trailing 1 already starts a ones run.
                                ones_cnt    <= 3'd1;
                                bit_cnt     <= 3'd0;
                                state       <= DATA;
                            end
                        end else if (zero_cnt != 3'd7) begin
                            zero_cnt <= zero_cnt + 3'd1;
                        end
                    end
                end
                DATA: begin
                    // End of packet takes priority over a coincident data bit.
                    if (rx_eop) begin
                        rx_pkt_end   <= 1'b1;
                        rx_active    <= 1'b0;
                        rx_align_err <= (bit_cnt != 3'd0);
                        zero_cnt     <= 3'd0;
                        state        <= HUNT;
                    end else if (rx_data_valid) begin
                        if (ones_cnt == STUFF_AT) begin
                            // Bit after a full ones run must be a stuffed 0.
                            if (rx_data_in) begin
                                rx_stuff_err <= 1'b1;
                                state        <= ERR;
                            end else begin
                                ones_cnt <= 3'd0;
                            end
                        end else begin
                            shreg[bit_cnt] <= rx_data_in;
                            ones_cnt       <= rx_data_in ? ones_cnt + 3'd1 : 3'd0;
                            bit_cnt        <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_byte       <= {rx_data_in, shreg[6:0]};
                                rx_byte_valid <= 1'b1;
                            end
                        end
                    end
                end
                ERR: begin
                    // Wait out the corrupted packet silently until its end.
                    if (rx_eop) begin
                        rx_pkt_end <= 1'b1;
                        rx_active  <= 1'b0;
                        zero_cnt   <= 3'd0;
                        state      <= HUNT;
                    end
                end
                default: begin
                    state     <= HUNT;
                    rx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_bit_unstuff.sv
// tb/tb_usb_rx_bit_unstuff.sv - table-driven bench for usb_rx_bit_unstuff
module tb_usb_rx_bit_unstuff;

    logic       gclk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_data_in = 1'b0;
    logic       rx_data_valid = 1'b0;
    logic       rx_eop = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_sync_det;
    logic       rx_pkt_end;
    logic       rx_stuff_err;
    logic       rx_align_err;
    logic       rx_active;

    always #5 gclk = ~gclk;

    usb_rx_bit_unstuff #(.SYNC_MIN_ZEROS(5), .STUFF_LEN(6)) dut (
        .gclk          (gclk),
        .reset         (reset),
        .rx_data_in    (rx_data_in),
        .rx_data_valid (rx_data_valid),
        .rx_eop        (rx_eop),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_sync_det   (rx_sync_det),
        .rx_pkt_end    (rx_pkt_end),
        .rx_stuff_err  (rx_stuff_err),
        .rx_align_err  (rx_align_err),
        .rx_active     (rx_active)
    );

    // flags = {byte_valid, sync_det, pkt_end, stuff_err, align_err, active}
    localparam logic [5:0] F_BV = 6'b100000;
    localparam logic [5:0] F_SY = 6'b010000;
    localparam logic [5:0] F_PE = 6'b001000;
    localparam logic [5:0] F_SE = 6'b000100;
    localparam logic [5:0] F_AE = 6'b000010;
    localparam logic [5:0] F_AC = 6'b000001;
    localparam logic [5:0] F_NO = 6'b000000;

    typedef struct {
        logic       rst;
        logic       eop;
        logic       vld;
        logic       din;
        logic [7:0] eb;
        logic [5:0] ef;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nmis = 0;

    task automatic v(input logic rst, input logic eop, input logic vld, input logic din,
                     input logic [7:0] eb, input logic [5:0] ef);
        vec_t r;
        r.rst = rst; r.eop = eop; r.vld = vld; r.din = din; r.eb = eb; r.ef = ef;
        tbl.push_back(r);
    endtask

    // Seven 0s then the SYNC trailing 1.
    task automatic sync_seq(input logic [7:0] eb);
        for (int i = 0; i < 7; i++) v(1'b0, 1'b0, 1'b1, 1'b0, eb, F_NO);
        v(1'b0, 1'b0, 1'b1, 1'b1, eb, F_SY | F_AC);
    endtask

    // Eight data bits LSB-first, no stuffing expected inside.
    task automatic byte_seq(input logic [7:0] d, input logic [7:0] prev, input int gap);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gap; g++) v(1'b0, 1'b0, 1'b0, g[0], prev, F_AC);
            if (i == 7) v(1'b0, 1'b0, 1'b1, d[i], d, F_BV | F_AC);
            else        v(1'b0, 1'b0, 1'b1, d[i], prev, F_AC);
        end
    endtask

    task automatic drive(input logic rst, input logic eop, input logic vld, input logic din);
        @(negedge gclk);
        reset = rst; rx_eop = eop; rx_data_valid = vld; rx_data_in = din;
        @(posedge gclk);
        #1;
    endtask

    task automatic check(input int idx, input logic [7:0] eb, input logic [5:0] ef);
        logic [5:0] af;
        af = {rx_byte_valid, rx_sync_det, rx_pkt_end, rx_stuff_err, rx_align_err, rx_active};
        nvec++;
        if (af !== ef || rx_byte !== eb) begin
            nmis++;
            $display("FAIL vec%0d: got byte=%02h flags=%06b, expected byte=%02h flags=%06b",
                     idx, rx_byte, af, eb, ef);
        end
    endtask

    initial begin
        logic       got;
        logic [7:0] cap;
        logic [7:0] d3c;
        int         npulse;

        // Reset state
        v(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, F_NO);
        v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, F_NO);

        // Plain byte 0xA5
        sync_seq(8'h00);
        byte_seq(8'hA5, 8'h00, 0);
        v(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, F_PE);
        v(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, F_NO);

        // Stuffed 0 after five data 1s is removed: 0xFF then 0x00
        sync_seq(8'hA5);
        for (int i = 0; i < 5; i++) v(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, F_AC);
        v(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, F_AC);
        v(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, F_AC);
        v(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, F_AC);
        v(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, F_BV | F_AC);
        byte_seq(8'h00, 8'hFF, 0);
        v(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, F_PE);

        // Stuff violation: 1 at the stuff point, then ignored data until EOP
        sync_seq(8'h00);
        for (int i = 0; i < 5; i++) v(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, F_AC);
        v(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, F_SE | F_AC);
        v(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, F_AC);
        v(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, F_AC);
        v(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, F_PE);
        v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, F_NO);

        // Twelve data bits: one byte then alignment error at EOP
        sync_seq(8'h00);
        byte_seq(8'h5A, 8'h00, 0);
        v(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, F_AC);
        v(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, F_AC);
        v(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, F_AC);
        v(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, F_AC);
        v(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, F_PE | F_AE);

        // EOP in HUNT clears the zero count
        for (int i = 0; i < 3; i++) v(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, F_NO);
        v(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, F_NO);
        v(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, F_NO);
        v(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, F_NO);
        v(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, F_NO);
        // Four zeros are not enough, exactly five are
        for (int i = 0; i < 4; i++) v(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, F_NO);
        v(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, F_NO);
        for (int i = 0; i < 5; i++) v(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, F_NO);
        v(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, F_SY | F_AC);
        // EOP together with a valid bit: EOP wins, no byte, no alignment error
        v(1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, F_PE);

        // Gapped valid, 1-in-3 cycles
        sync_seq(8'h5A);
        byte_seq(8'hC3, 8'h5A, 2);
        v(1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, F_AC);
        v(1'b0, 1'b1, 1'b0, 1'b0, 8'hC3, F_PE);

        // Reset mid-packet after three data bits: no pkt_end
        sync_seq(8'hC3);
        v(1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, F_AC);
        v(1'b0, 1'b0, 1'b1, 1'b0, 8'hC3, F_AC);
        v(1'b0, 1'b0, 1'b1, 1'b1, 8'hC3, F_AC);
        v(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, F_NO);
        v(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, F_NO);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].eop, tbl[i].vld, tbl[i].din);
            check(i, tbl[i].eb, tbl[i].ef);
        end

        // New packet after reset: 0x3C must come out intact, with a bounded wait for the byte
        got = 1'b0;
        cap = 8'h00;
        npulse = 0;
        d3c = 8'h3C;
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, d3c[i]);
            if (rx_byte_valid) begin got = 1'b1; cap = rx_byte; npulse++; end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            if (rx_byte_valid) begin got = 1'b1; cap = rx_byte; npulse++; end
        end
        nvec++;
        if (!got || cap !== 8'h3C || npulse != 1) begin
            nmis++;
            $display("FAIL post_reset_byte: got=%0b byte=%02h pulses=%0d, expected byte=3c pulses=1",
                     got, cap, npulse);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check(9999, 8'h3C, F_PE);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/usb_rx_bit_unstuff.md
# usb_rx_bit_unstuff

Receive-path stage directly downstream of the NRZI decoder in the USB 2.0 serial engine. Consumes the decoded serial bit stream and the end-of-packet strobe, hunts for the SYNC pattern, removes stuffed bits, flags bit-stuff violations, and deserializes packet contents LSB-first into bytes for the PID/packet parser.

## Interface
- SYNC_MIN_ZEROS, 5: minimum consecutive decoded 0s before a 1 to accept SYNC; legal range 1..7.
- STUFF_LEN, 6: ones-run length after which the next bit is a stuff bit.

- gclk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- rx_data_in  input  1  decoded bit from the NRZI decoder.
- rx_data_valid  input  1  qualifies rx_data_in; may be sparse.
- rx_eop  input  1  one-cycle end-of-packet strobe (SE0 seen upstream).
- rx_byte  output  8  assembled byte, first-received bit in bit 0.
- rx_byte_valid  output  1  one-cycle pulse, rx_byte is new.
- rx_sync_det  output  1  one-cycle pulse on SYNC acceptance.
- rx_pkt_end  output  1  one-cycle pulse on packet close.
- rx_stuff_err  output  1  one-cycle pulse on stuff violation.
- rx_align_err  output  1  one-cycle pulse; packet ended mid-byte.
- rx_active  output  1  high while a packet is open.

## Operation
- States: HUNT, DATA, ERR. Reset -> HUNT.
- HUNT: zero_cnt (saturating at 7) increments per valid 0, clears on valid 1. Valid 1 with zero_cnt >= SYNC_MIN_ZEROS -> pulse rx_sync_det, ones_cnt := 1 (SYNC trailing 1 counts toward stuffing), bit_cnt := 0, -> DATA. rx_eop in HUNT: ignored, zero_cnt := 0.
- DATA, valid bit, ones_cnt < STUFF_LEN: shift bit into shreg at position bit_cnt; ones_cnt := bit ? ones_cnt+1 : 0; bit_cnt := bit_cnt+1 (3-bit, wraps 7->0). On wrap: rx_byte := completed shreg, pulse rx_byte_valid.
- DATA, valid bit, ones_cnt == STUFF_LEN: bit is a stuff bit. 0 -> discard, ones_cnt := 0, bit_cnt unchanged. 1 -> pulse rx_stuff_err, -> ERR; no partial byte emitted.
- DATA, rx_eop: pulse rx_pkt_end; if bit_cnt != 0 also pulse rx_align_err and discard the partial byte; -> HUNT, zero_cnt := 0.
- ERR: all data ignored; rx_eop -> pulse rx_pkt_end, -> HUNT. No byte or further error pulses in ERR.
- rx_active = 1 in DATA and ERR, 0 in HUNT.
- rx_eop and rx_data_valid in the same cycle: rx_eop wins, the bit is discarded.

## Timing
- All outputs registered. Reset values: rx_byte 8'h00, every pulse output 0, rx_active 0; all counters 0.
- rx_byte_valid rises the cycle after the valid cycle carrying the 8th data bit; rx_byte holds until the next byte.
- rx_sync_det, rx_stuff_err, rx_pkt_end, rx_align_err: one cycle after the triggering input cycle.
- rx_active rises with rx_sync_det and falls with rx_pkt_end.
- Cycles with rx_data_valid = 0 change nothing (except rx_eop handling).
- Reset mid-packet: next edge returns to HUNT with reset values; no rx_pkt_end is produced.
- Throughput: one bit per cycle sustained, no backpressure.

## Test plan
- SYNC (0000_0001) then data bits of 0xA5 LSB-first, rx_eop -> rx_sync_det, one rx_byte_valid with 0xA5, rx_pkt_end, no error pulses.
- SYNC, then 1,1,1,1,1,0(stuff),1,1,1, then 0x00 bits, rx_eop -> bytes 0xFF then 0x00; stuff 0 removed, no rx_stuff_err.
- SYNC, then six 1s, stuff point receives 1 -> rx_stuff_err pulse, no byte, rx_active stays 1 until rx_eop, then rx_pkt_end, rx_active 0.
- SYNC, 12 data bits, rx_eop -> one rx_byte_valid, then rx_pkt_end and rx_align_err in the same cycle.
- Only four 0s before the 1 (SYNC_MIN_ZEROS=5) -> no rx_sync_det, rx_active stays 0; subsequent valid SYNC detected normally.
- SYNC, data with rx_data_valid gapped at 1-in-3 cycles -> same bytes as ungapped; reset asserted after 3 data bits -> all outputs at reset values next cycle; new SYNC + 0x3C -> rx_byte 0x3C.
